flash_to_sram_loader: RTL

//  Copy engine that is a client of external_memory_controller's internal req/idle ports. On start it copies

---
 rtl/flash_to_sram_loader_if.sv | 25 ++
 rtl/flash_to_sram_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/flash_to_sram_loader_if.sv
// Request/idle handshake bundle between the boot-image loader and the external memory controller.
interface flash_to_sram_loader_if;
  logic        flash_read_req;
  logic [19:0] flash_read_address;
  logic [7:0]  flash_read_data;
  logic        flash_read_idle;
  logic        sram_write_req;
  logic [17:0] sram_write_address;
  logic [7:0]  sram_write_data;
  logic        sram_write_idle;

  modport master (
    output flash_read_req, flash_read_address,
    input  flash_read_data, flash_read_idle,
    output sram_write_req, sram_write_address, sram_write_data,
    input  sram_write_idle
  );

  modport slave (
    input  flash_read_req, flash_read_address,
    output flash_read_data, flash_read_idle,
    input  sram_write_req, sram_write_address, sram_write_data,
    output sram_write_idle
  );
endinterface

// File: rtl/flash_to_sram_loader.sv
// Boot-time copy engine: streams LENGTH bytes from flash to SRAM through the memory controller,
// one read/write pair per byte, accumulating a 16-bit additive checksum.
module flash_to_sram_loader #(
  parameter int LEN_W          = 18,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK_40,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [19:0]            src_addr,
  input  logic [17:0]            dst_addr,
  input  logic [LEN_W-1:0]       length,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   aborted,
  output logic [LEN_W-1:0]       bytes_done,
  output logic [15:0]            checksum,
  flash_to_sram_loader_if.master mem
);

  typedef enum logic [3:0] {
    IDLE, FRD_REQ, FRD_WAIT, FRD_SETTLE, SWR_REQ, SWR_WAIT, SWR_SETTLE, NEXT, DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [19:0]      src;
  logic [17:0]      dst;
  logic [LEN_W-1:0] len;
  logic [7:0]       data_byte;
  logic [7:0]       tmo;
  logic             abort_pending;
  logic             frd_req;
  logic             swr_req;
  logic             advance;
  logic             in_handshake;
  logic [LEN_W-1:0] next_count;

  assign mem.flash_read_req     = frd_req;
  assign mem.flash_read_address = src;
  assign mem.sram_write_req     = swr_req;
  assign mem.sram_write_address = dst;
  assign mem.sram_write_data    = data_byte;

  assign next_count   = bytes_done + 1'b1;
  assign in_handshake = state inside {FRD_REQ, FRD_WAIT, FRD_SETTLE, SWR_REQ, SWR_WAIT, SWR_SETTLE};

  // Settle states need tmo != 0 so the controller gets one cycle to show a repeated op as busy.
  always_comb begin
    advance = 1'b0;
    case (state)
      FRD_REQ:    advance = !mem.flash_read_idle;
      FRD_WAIT:   advance = mem.flash_read_idle;
      FRD_SETTLE: advance = (tmo != 8'd0) && mem.flash_read_idle;
      SWR_REQ:    advance = !mem.sram_write_idle;
      SWR_WAIT:   advance = mem.sram_write_idle;
      SWR_SETTLE: advance = (tmo != 8'd0) && mem.sram_write_idle;
      default:    advance = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      len           <= '0;
      data_byte     <= '0;
      tmo           <= '0;
      abort_pending <= 1'b0;
      frd_req       <= 1'b0;
      swr_req       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      aborted       <= 1'b0;
      bytes_done    <= '0;
      checksum      <= '0;
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_pending <= 1'b1;

      if (in_handshake && !advance) begin
        if (tmo == TMO_LAST) begin
          frd_req <= 1'b0;
          swr_req <= 1'b0;
          error   <= 1'b1;
          state   <= DONE;
        end else begin
          tmo <= tmo + 8'd1;
        end
      end else begin
        tmo <= '0;
        case (state)
          IDLE: if (start) begin
            src           <= src_addr;
            dst           <= dst_addr;
            len           <= length;
            bytes_done    <= '0;
            checksum      <= '0;
            error         <= 1'b0;
            aborted       <= 1'b0;
            abort_pending <= 1'b0;
            busy          <= 1'b1;
            if (length == '0) begin
              state <= DONE;
            end else begin
              frd_req <= 1'b1;
              state   <= FRD_REQ;
            end
          end
          FRD_REQ:  state <= FRD_WAIT;
          FRD_WAIT: begin
            data_byte <= mem.flash_read_data;
            frd_req   <= 1'b0;
            state     <= FRD_SETTLE;
          end
          FRD_SETTLE: begin
            swr_req <= 1'b1;
            state   <= SWR_REQ;
          end
          SWR_REQ:  state <= SWR_WAIT;
          SWR_WAIT: begin
            swr_req <= 1'b0;
            state   <= SWR_SETTLE;
          end
          SWR_SETTLE: state <= NEXT;
          NEXT: begin
            bytes_done <= next_count;
            checksum   <= checksum + {8'h00, data_byte};
            src        <= src + 20'd1;
            dst        <= dst + 18'd1;
            if (next_count == len) begin
              state <= DONE;
            end else if (abort_pending) begin
              aborted <= 1'b1;
              state   <= DONE;
            end else begin
              frd_req <= 1'b1;
              state   <= FRD_REQ;
            end
          end
          DONE: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            frd_req <= 1'b0;
            swr_req <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
